// File: rtl/mnist_frame_feeder.sv
// Input stage of the MNIST CNN core: buffers one 28x28 frame from the host, replays it to the
// core as a row-major pixel burst, then returns the classified digit to the host.
module mnist_frame_feeder #(
  parameter int GS_BITS        = 8,
  parameter int BCD_BITS       = 4,
  parameter int PIX_COUNT      = 784,
  parameter int PIX_ADDR_BITS  = 10,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [GS_BITS-1:0]  s_pixel,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [GS_BITS-1:0]  pixel_o,
  output logic                pixel_o_valid,
  input  logic [BCD_BITS-1:0] digit_i,
  input  logic                digit_i_valid,
  output logic [BCD_BITS-1:0] result_o,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                frame_err,
  output logic                busy
);

  // state       | meaning
  // LOAD        | accepting host beats into the frame RAM
  // STREAM      | replaying the frame to the core
  // WAIT_RESULT | waiting for the core's digit, with timeout
  // HOLD        | presenting the digit until the host takes it
  typedef enum logic [1:0] {LOAD, STREAM, WAIT_RESULT, HOLD} state_t;

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [PIX_ADDR_BITS-1:0] LAST_ADDR = PIX_ADDR_BITS'(PIX_COUNT - 1);
  localparam logic [GAP_W-1:0]         GAP_LOAD  = GAP_W'(GAP_CYCLES);
  localparam logic [16:0]              TMO_LAST  = 17'(TIMEOUT_CYCLES - 1);
  localparam logic [BCD_BITS-1:0]      DIGIT_MAX = BCD_BITS'(9);

  state_t state, state_nxt;
  logic   err_nxt;

  logic [GS_BITS-1:0]       ram [PIX_COUNT];
  logic [GS_BITS-1:0]       ram_q;
  logic [PIX_ADDR_BITS-1:0] wr_cnt;
  logic [PIX_ADDR_BITS-1:0] rd_cnt;
  logic                     rd_done;
  logic [GAP_W-1:0]         gap_cnt;
  logic                     rd_vld;
  logic                     rd_last;
  logic [16:0]              tmo_cnt;

  logic beat, wr_last, rd_issue, digit_ok;

  assign beat     = s_valid && (state == LOAD);
  assign wr_last  = (wr_cnt == LAST_ADDR);
  assign rd_issue = (state == STREAM) && !rd_done && (gap_cnt == '0);
  assign digit_ok = (digit_i <= DIGIT_MAX);

  assign s_ready      = (state == LOAD);
  assign busy         = (state != LOAD);
  assign result_valid = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    unique case (state)
      LOAD: begin
        if (beat) begin
          if (wr_last && s_last)     state_nxt = STREAM;
          else if (wr_last || s_last) err_nxt  = 1'b1;
        end
      end
      // leave STREAM on the edge that presents the final pixel
      STREAM: begin
        if (rd_vld && rd_last) state_nxt = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (digit_i_valid) begin
          if (digit_ok) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = LOAD;
            err_nxt   = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = LOAD;
          err_nxt   = 1'b1;
        end
      end
      HOLD: begin
        if (result_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // frame RAM has no reset so contents survive a reset
  always_ff @(posedge clk) begin
    if (beat)     ram[wr_cnt] <= s_pixel;
    if (rd_issue) ram_q <= ram[rd_cnt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (beat) begin
      if (wr_last || s_last) wr_cnt <= '0;
      else                   wr_cnt <= wr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      rd_done <= 1'b0;
      gap_cnt <= '0;
    end else if (state != STREAM) begin
      rd_cnt  <= '0;
      rd_done <= 1'b0;
      gap_cnt <= '0;
    end else if (rd_issue) begin
      rd_cnt  <= rd_cnt + 1'b1;
      rd_done <= (rd_cnt == LAST_ADDR);
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld        <= 1'b0;
      rd_last       <= 1'b0;
      pixel_o_valid <= 1'b0;
      pixel_o       <= '0;
    end else begin
      rd_vld        <= rd_issue;
      rd_last       <= rd_issue && (rd_cnt == LAST_ADDR);
      pixel_o_valid <= rd_vld;
      pixel_o       <= rd_vld ? ram_q : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= '0;
      result_o  <= '0;
      frame_err <= 1'b0;
    end else begin
      tmo_cnt   <= (state == WAIT_RESULT) ? tmo_cnt + 1'b1 : '0;
      frame_err <= err_nxt;
      if (state == WAIT_RESULT && digit_i_valid && digit_ok) result_o <= digit_i;
    end
  end

endmodule
